spi_master_cfg: RTL and testbench

- Parametrised SPI master, successor to the fixed mode-0 divide-by-2 master.
- Adds a programmable SCLK divider, all four CPOL/CPHA modes per transfer, NUM_CS decoded chip selects, and a ready/start handshake with a done pulse.
- Sits between a register/command front end and off-chip SPI slaves.
- One full-duplex word per transfer, MSB first.

---
 rtl/spi_master_cfg.sv | 193 +++++++++++++++++++
 tb/tb_spi_master_cfg.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_cfg.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_cfg
// Purpose  : SPI master with a programmable SCLK divider, per-transfer
//            CPOL/CPHA, decoded active-low chip selects and a start/ready/done
//            handshake. Optional LSB-first transfers via
//            SPI_MASTER_CFG_LSB_FIRST_EN.
// Revision : 1.0 - initial release
// ============================================================================
module spi_master_cfg #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CS     = 4,
    parameter int CLK_DIV    = 2,
    parameter int CSW        = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  ready,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [CSW-1:0]        cs_sel,
    input  logic                  cpol,
    input  logic                  cpha,
`ifdef SPI_MASTER_CFG_LSB_FIRST_EN
    input  logic                  lsb_first,
`endif
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  done,
    output logic                  busy,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic [NUM_CS-1:0]     cs_n
);

    localparam int c_EDGES = 2 * DATA_WIDTH;
    localparam int c_ECW   = $clog2(2 * DATA_WIDTH + 1);
    localparam int c_DCW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SETUP = 2'd1;
    localparam logic [1:0] c_XFER  = 2'd2;
    localparam logic [1:0] c_HOLD  = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_next;
    logic [c_DCW-1:0]      r_div;
    logic [c_ECW-1:0]      r_edge;
    logic                  r_cpol;
    logic                  r_cpha;
    logic                  r_sclk;
    logic                  r_mosi;
    logic                  r_done;
    logic [NUM_CS-1:0]     r_cs_n;
    logic [NUM_CS-1:0]     w_cs_dec;
    logic [DATA_WIDTH-1:0] r_tx;
    logic [DATA_WIDTH-1:0] r_rx;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic [DATA_WIDTH-1:0] w_load;
    logic [DATA_WIDTH-1:0] w_rx_word;
    logic                  w_accept;
    logic                  w_tick;
    logic                  w_last_edge;
    logic                  w_sample;

    assign w_accept    = start && (r_state == c_IDLE);
    assign w_tick      = (r_div == c_DCW'(CLK_DIV - 1));
    assign w_last_edge = (r_edge == c_ECW'(c_EDGES - 1));
    // Edge number r_edge+1 is leading when odd; sampling happens on leading
    // edges for cpha=0 and on trailing edges for cpha=1.
    assign w_sample    = (~r_edge[0]) ^ r_cpha;

    for (genvar i = 0; i < NUM_CS; i++) begin : g_cs_dec
        assign w_cs_dec[i] = (cs_sel != CSW'(i));
    end

`ifdef SPI_MASTER_CFG_LSB_FIRST_EN
    logic                  r_lsb;
    logic [DATA_WIDTH-1:0] w_data_rev;
    logic [DATA_WIDTH-1:0] w_rx_rev;

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_rev
        assign w_data_rev[i] = data_in[DATA_WIDTH-1-i];
        assign w_rx_rev[i]   = r_rx[DATA_WIDTH-1-i];
    end

    assign w_load    = lsb_first ? w_data_rev : data_in;
    assign w_rx_word = r_lsb ? w_rx_rev : r_rx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)         r_lsb <= 1'b0;
        else if (w_accept) r_lsb <= lsb_first;
    end
`else
    assign w_load    = data_in;
    assign w_rx_word = r_rx;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= c_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  if (w_accept)               w_next = c_SETUP;
            c_SETUP: if (w_tick)                 w_next = c_XFER;
            c_XFER:  if (w_tick && w_last_edge)  w_next = c_HOLD;
            c_HOLD:  if (w_tick)                 w_next = c_IDLE;
            default:                             w_next = c_IDLE;
        endcase
    end

    always_comb begin
        ready = (r_state == c_IDLE);
        busy  = (r_state != c_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div  <= '0;
            r_edge <= '0;
        end else begin
            if (r_state == c_IDLE || w_tick) r_div <= '0;
            else                             r_div <= r_div + 1'b1;
            if (w_accept)                          r_edge <= '0;
            else if (r_state == c_XFER && w_tick)  r_edge <= r_edge + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_done     <= 1'b0;
            r_cs_n     <= '1;
            r_tx       <= '0;
            r_rx       <= '0;
            r_data_out <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_cpol <= cpol;
                        r_cpha <= cpha;
                        r_sclk <= cpol;
                        r_cs_n <= w_cs_dec;
                        r_rx   <= '0;
                        // cpha=0 presents the first bit before the first edge
                        if (!cpha) begin
                            r_mosi <= w_load[DATA_WIDTH-1];
                            r_tx   <= {w_load[DATA_WIDTH-2:0], 1'b0};
                        end else begin
                            r_tx   <= w_load;
                        end
                    end
                end
                c_XFER: begin
                    if (w_tick) begin
                        r_sclk <= ~r_sclk;
                        if (w_sample) begin
                            r_rx <= {r_rx[DATA_WIDTH-2:0], miso};
                        end else if (r_cpha || !w_last_edge) begin
                            r_mosi <= r_tx[DATA_WIDTH-1];
                            r_tx   <= {r_tx[DATA_WIDTH-2:0], 1'b0};
                        end
                    end
                end
                c_HOLD: begin
                    r_sclk <= r_cpol;
                    if (w_tick) begin
                        r_cs_n     <= '1;
                        r_data_out <= w_rx_word;
                        r_done     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sclk     = r_sclk;
    assign mosi     = r_mosi;
    assign cs_n     = r_cs_n;
    assign done     = r_done;
    assign data_out = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_cfg.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_master_cfg
// Purpose  : Self-checking bench for spi_master_cfg with a behavioural SPI
//            slave and randomized transfers.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_spi_master_cfg;

    localparam int W    = 8;
    localparam int NCS  = 4;
    localparam int DIV  = 2;
    localparam int NCS1 = 5;
    localparam int LAT  = DIV * (2 * W + 2);
    localparam int LAT1 = 1 * (2 * W + 2);

    logic clk = 1'b0, reset = 1'b1, start = 1'b0, start1 = 1'b0;
    logic [W-1:0] data_in = '0;
    logic [1:0]   cs_sel = '0;
    logic [2:0]   cs_sel1 = '0;
    logic         cpol = 1'b0, cpha = 1'b0;
    logic         ready, done, busy, sclk, mosi, miso;
    logic [W-1:0] data_out;
    logic [NCS-1:0] cs_n;
    logic         ready1, done1, busy1, sclk1, mosi1;
    logic [W-1:0] data_out1;
    logic [NCS1-1:0] cs_n1;
`ifdef SPI_MASTER_CFG_LSB_FIRST_EN
    logic lsb_first = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    spi_master_cfg #(.DATA_WIDTH(W), .NUM_CS(NCS), .CLK_DIV(DIV)) dut (
        .clk(clk), .reset(reset), .start(start), .ready(ready),
        .data_in(data_in), .cs_sel(cs_sel), .cpol(cpol), .cpha(cpha),
`ifdef SPI_MASTER_CFG_LSB_FIRST_EN
        .lsb_first(lsb_first),
`endif
        .data_out(data_out), .done(done), .busy(busy), .sclk(sclk),
        .mosi(mosi), .miso(miso), .cs_n(cs_n)
    );

    spi_master_cfg #(.DATA_WIDTH(W), .NUM_CS(NCS1), .CLK_DIV(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .ready(ready1),
        .data_in(data_in), .cs_sel(cs_sel1), .cpol(cpol), .cpha(cpha),
`ifdef SPI_MASTER_CFG_LSB_FIRST_EN
        .lsb_first(lsb_first),
`endif
        .data_out(data_out1), .done(done1), .busy(busy1), .sclk(sclk1),
        .mosi(mosi1), .miso(mosi1), .cs_n(cs_n1)
    );

    // Behavioural SPI slave: knows the mode from the bench, not from the DUT.
    logic         loopback = 1'b1, m_cpol = 1'b0, m_cpha = 1'b0;
    logic [W-1:0] slv_tx = '0, slv_rx = '0;
    logic         slv_miso = 1'b0;
    int           slv_samples = 0, slv_idx = 0, slv_edges = 0;
    wire          cs_idle = &cs_n;

    assign miso = loopback ? mosi : slv_miso;

    always @(negedge cs_idle) begin
        slv_rx = '0;
        slv_samples = 0;
        slv_edges = 0;
        if (!m_cpha) begin
            slv_miso = slv_tx[W-1];
            slv_idx  = 1;
        end else begin
            slv_idx  = 0;
        end
    end

    always @(posedge cs_idle) slv_edges = 0;

    always @(sclk) begin
        if (!cs_idle && ((sclk != m_cpol) || (slv_edges % 2 == 1))) begin
            slv_edges++;
            if ((sclk != m_cpol) != m_cpha) begin
                slv_rx = {slv_rx[W-2:0], mosi};
                slv_samples++;
            end else if (slv_idx < W) begin
                slv_miso = slv_tx[W-1-slv_idx];
                slv_idx++;
            end
        end
    end

    task automatic run_xfer(input logic [W-1:0] d, input logic pol, input logic pha,
                            input logic [1:0] cs, input logic lb, input logic [W-1:0] sw,
                            input logic poke, input string tag);
        int cnt, toggles, cs_bad, extra;
        logic prev;
        logic [NCS-1:0] exp_cs;
        logic [W-1:0] exp_do;
        exp_cs = '1;
        exp_cs[cs] = 1'b0;
        exp_do = lb ? d : sw;
        loopback = lb; slv_tx = sw; m_cpol = pol; m_cpha = pha;
        cnt = 0;
        @(negedge clk);
        while (ready !== 1'b1 && cnt < 200) begin @(negedge clk); cnt++; end
        data_in = d; cpol = pol; cpha = pha; cs_sel = cs; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++;
        if (ready !== 1'b0 || sclk !== pol || cs_n !== exp_cs) begin
            n_bad++;
            $display("FAIL %s accept: ready=%b sclk=%b cs_n=%h, required ready=0 sclk=%b cs_n=%h",
                     tag, ready, sclk, cs_n, pol, exp_cs);
        end
        data_in = W'($urandom); cpol = ~pol; cpha = ~pha; cs_sel = 2'($urandom);
        cnt = 0; toggles = 0; cs_bad = 0; prev = sclk;
        while (done !== 1'b1 && cnt < LAT + 20) begin
            if (cs_n !== exp_cs || busy !== 1'b1) cs_bad++;
            @(posedge clk); #1;
            cnt++;
            start = poke && (cnt == LAT / 2);
            if (sclk !== prev) toggles++;
            prev = sclk;
        end
        start = 1'b0;
        n_cmp++;
        if (cnt != LAT) begin
            n_bad++;
            $display("FAIL %s latency: got %0d cycles, required %0d", tag, cnt, LAT);
        end
        n_cmp++;
        if (cs_bad != 0 || toggles != 2 * W) begin
            n_bad++;
            $display("FAIL %s framing: cs/busy errors %0d sclk toggles %0d, required 0 and %0d",
                     tag, cs_bad, toggles, 2 * W);
        end
        n_cmp++;
        if (data_out !== exp_do) begin
            n_bad++;
            $display("FAIL %s data_out: got %h, required %h", tag, data_out, exp_do);
        end
        n_cmp++;
        if (slv_rx !== d || slv_samples != W) begin
            n_bad++;
            $display("FAIL %s slave capture: got %h in %0d samples, required %h in %0d",
                     tag, slv_rx, slv_samples, d, W);
        end
        n_cmp++;
        if (cs_n !== '1 || sclk !== pol || ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s end state: cs_n=%h sclk=%b ready=%b, required cs_n=f sclk=%b ready=1",
                     tag, cs_n, sclk, ready, pol);
        end
        extra = 0;
        repeat (poke ? 2 * LAT : 1) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || ready !== 1'b1) extra++;
        end
        n_cmp++;
        if (extra != 0) begin
            n_bad++;
            $display("FAIL %s single done: %0d extra done/busy cycles, required 0", tag, extra);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({ready, busy, done, sclk, mosi} !== 5'b10000 || cs_n !== 4'hF || data_out !== '0) begin
            n_bad++;
            $display("FAIL reset: rdy/bsy/done/sclk/mosi=%b cs_n=%h data_out=%h, required 10000 f 00",
                     {ready, busy, done, sclk, mosi}, cs_n, data_out);
        end
        n_cmp++;
        if (ready1 !== 1'b1 || cs_n1 !== 5'h1F || sclk1 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset1: ready=%b cs_n=%h sclk=%b, required 1 1f 0", ready1, cs_n1, sclk1);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_modes;
        run_xfer(8'hA5, 1'b0, 1'b0, 2'd0, 1'b1, 8'h00, 1'b0, "mode0_loop");
        run_xfer(8'hC3, 1'b1, 1'b1, 2'd1, 1'b0, 8'h3C, 1'b0, "mode3_slave");
        run_xfer(8'h81, 1'b0, 1'b1, 2'd3, 1'b0, W'($urandom), 1'b0, "mode1");
        run_xfer(8'h81, 1'b1, 1'b0, 2'd0, 1'b0, W'($urandom), 1'b0, "mode2");
        for (int i = 0; i < 8; i++)
            run_xfer(W'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
                     1'($urandom), W'($urandom), 1'b0, "random");
    endtask

    task automatic test_cs_select;
        run_xfer(W'($urandom), 1'b0, 1'b0, 2'd2, 1'b0, W'($urandom), 1'b0, "cs2");
    endtask

    task automatic test_ignore_start;
        run_xfer(W'($urandom), 1'b1, 1'b0, 2'd1, 1'b1, 8'h00, 1'b1, "start_while_busy");
    endtask

    task automatic test_back_to_back;
        int cnt, hi, nd, t1, t2;
        logic [W-1:0] d1, d2, got1, got2;
        d1 = W'($urandom); d2 = W'($urandom);
        loopback = 1'b1; m_cpol = 1'b0; m_cpha = 1'b0;
        got1 = '0; got2 = '0;
        cnt = 0;
        @(negedge clk);
        while (ready !== 1'b1 && cnt < 200) begin @(negedge clk); cnt++; end
        data_in = d1; cpol = 1'b0; cpha = 1'b0; cs_sel = 2'd0; start = 1'b1;
        @(posedge clk); #1;
        cnt = 0; hi = 0; nd = 0; t1 = -1; t2 = -1;
        while (cnt < 2 * LAT + 5) begin
            @(posedge clk); #1;
            cnt++;
            if (cnt == 10) data_in = d2;
            if (cnt == 2 * LAT + 1) start = 1'b0;
            if (done === 1'b1) begin
                nd++;
                if (t1 < 0) begin t1 = cnt; got1 = data_out; end
                else        begin t2 = cnt; got2 = data_out; end
            end
            if (cnt < 2 * LAT + 1 && cs_n === 4'hF) hi++;
        end
        start = 1'b0;
        n_cmp++;
        if (nd != 2 || t1 != LAT || t2 != 2 * LAT + 1) begin
            n_bad++;
            $display("FAIL b2b timing: %0d dones at %0d/%0d, required 2 at %0d/%0d",
                     nd, t1, t2, LAT, 2 * LAT + 1);
        end
        n_cmp++;
        if (hi != 1) begin
            n_bad++;
            $display("FAIL b2b cs gap: cs_n high %0d cycles, required 1", hi);
        end
        n_cmp++;
        if (got1 !== d1 || got2 !== d2) begin
            n_bad++;
            $display("FAIL b2b data: got %h/%h, required %h/%h", got1, got2, d1, d2);
        end
    endtask

    task automatic run_xfer1(input logic [W-1:0] d, input logic [2:0] cs, input string tag);
        int cnt, cs_bad;
        logic [NCS1-1:0] exp_cs;
        exp_cs = '1;
        if (cs < NCS1) exp_cs[cs] = 1'b0;
        @(negedge clk);
        data_in = d; cpol = 1'b0; cpha = 1'b0; cs_sel1 = cs; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        data_in = W'($urandom);
        cnt = 0; cs_bad = 0;
        while (done1 !== 1'b1 && cnt < LAT1 + 20) begin
            if (cs_n1 !== exp_cs) cs_bad++;
            @(posedge clk); #1;
            cnt++;
        end
        n_cmp++;
        if (cnt != LAT1 || cs_bad != 0) begin
            n_bad++;
            $display("FAIL %s: latency %0d cs errors %0d, required %0d and 0", tag, cnt, cs_bad, LAT1);
        end
        n_cmp++;
        if (data_out1 !== d || cs_n1 !== 5'h1F) begin
            n_bad++;
            $display("FAIL %s result: data_out=%h cs_n=%h, required %h 1f", tag, data_out1, cs_n1, d);
        end
    endtask

    task automatic test_reset_abort;
        int cnt, nd;
        loopback = 1'b1; m_cpol = 1'b1; m_cpha = 1'b0;
        cnt = 0;
        @(negedge clk);
        while (ready !== 1'b1 && cnt < 200) begin @(negedge clk); cnt++; end
        data_in = W'($urandom); cpol = 1'b1; cpha = 1'b0; cs_sel = 2'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (16) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++;
        if (cs_n !== 4'hF || sclk !== 1'b0 || ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL abort: cs_n=%h sclk=%b ready=%b busy=%b, required f 0 1 0",
                     cs_n, sclk, ready, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        nd = 0;
        repeat (LAT + 10) begin
            @(posedge clk); #1;
            if (done !== 1'b0) nd++;
        end
        n_cmp++;
        if (nd != 0) begin
            n_bad++;
            $display("FAIL abort done: %0d done cycles after abort, required 0", nd);
        end
        run_xfer1(8'h5A, 3'd0, "div1_loop");
        run_xfer1(W'($urandom), 3'd5, "cs_out_of_range");
    endtask

    initial begin
        test_reset();
        test_modes();
        test_cs_select();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
